// File: rtl/cs_frame_sequencer.sv
// Frame controller for the CS-ECG datapath: arm, stream N samples, wait for the encoder, read out M words.
// Define CS_SEQ_TIMEOUT_EN to add a WAIT_ENC watchdog that aborts after TIMEOUT cycles.
module cs_frame_sequencer #(
  parameter int N       = 2048,
  parameter int M       = 512,
  parameter int DW      = 12,
  parameter int MW      = 24,
  parameter int TIMEOUT = 8192
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DW-1:0]        sample_in,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  output logic                 dp_reset,
  output logic                 th_enable,
  output logic [DW-1:0]        th_sig,
  input  logic                 enc_done,
  output logic [$clog2(M)-1:0] meas_addr,
  input  logic [MW-1:0]        meas_data,
  output logic [MW-1:0]        out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic                 err_underrun,
  output logic                 err_timeout
);

  localparam int SCW = $clog2(N) + 1;
  localparam int AW  = $clog2(M);
  localparam logic [SCW-1:0] SAMPLE_LAST = SCW'(N - 1);
  localparam logic [AW-1:0]  RD_LAST     = AW'(M - 1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_ARM_RST  = 4'd1,
    S_ARM_EN   = 4'd2,
    S_STREAM   = 4'd3,
    S_WAIT_ENC = 4'd4,
    S_RD_ADDR  = 4'd5,
    S_RD_WAIT  = 4'd6,
    S_RD_OUT   = 4'd7,
    S_ABORT    = 4'd8
  } state_t;

  state_t         state_r, state_s;
  logic [SCW-1:0] sample_cnt_r;
  logic [AW-1:0]  rd_cnt_r;
  logic [DW-1:0]  th_sig_r;
  logic [MW-1:0]  out_data_r;
  logic           sample_ready_r, dp_reset_r, th_enable_r, out_valid_r, out_last_r, busy_r;
  logic           sample_ready_s, dp_reset_s, th_enable_s, out_valid_s, out_last_s, busy_s;
  logic           err_underrun_r;
  logic           timeout_hit_s;

  // State register; control outputs are registered from the next-state decode so they align with the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= S_IDLE;
      sample_ready_r <= 1'b0;
      dp_reset_r     <= 1'b1;
      th_enable_r    <= 1'b0;
      out_valid_r    <= 1'b0;
      out_last_r     <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      sample_ready_r <= sample_ready_s;
      dp_reset_r     <= dp_reset_s;
      th_enable_r    <= th_enable_s;
      out_valid_r    <= out_valid_s;
      out_last_r     <= out_last_s;
      busy_r         <= busy_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_s = S_ARM_RST;
        else       state_s = S_IDLE;
      end
      S_ARM_RST: state_s = S_ARM_EN;
      S_ARM_EN:  state_s = S_STREAM;
      S_STREAM: begin
        if (!sample_valid)                    state_s = S_ABORT;
        else if (sample_cnt_r == SAMPLE_LAST) state_s = S_WAIT_ENC;
        else                                  state_s = S_STREAM;
      end
      S_WAIT_ENC: begin
        if (enc_done)           state_s = S_RD_ADDR;
        else if (timeout_hit_s) state_s = S_ABORT;
        else                    state_s = S_WAIT_ENC;
      end
      S_RD_ADDR: state_s = S_RD_WAIT;
      S_RD_WAIT: state_s = S_RD_OUT;
      S_RD_OUT: begin
        if (!out_ready)              state_s = S_RD_OUT;
        else if (rd_cnt_r == RD_LAST) state_s = S_IDLE;
        else                          state_s = S_RD_ADDR;
      end
      S_ABORT: state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Output decode of the upcoming state
  always_comb begin
    sample_ready_s = (state_s == S_STREAM);
    dp_reset_s     = (state_s == S_ARM_RST) || (state_s == S_ABORT);
    th_enable_s    = (state_s == S_ARM_EN);
    out_valid_s    = (state_s == S_RD_OUT);
    out_last_s     = (state_s == S_RD_OUT) && (rd_cnt_r == RD_LAST);
    busy_s         = (state_s != S_IDLE);
  end

  // Counters, sample/measurement capture and underrun flag
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_cnt_r   <= '0;
      rd_cnt_r       <= '0;
      th_sig_r       <= '0;
      out_data_r     <= '0;
      err_underrun_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            sample_cnt_r   <= '0;
            rd_cnt_r       <= '0;
            err_underrun_r <= 1'b0;
          end
        end
        S_STREAM: begin
          if (sample_valid) begin
            th_sig_r <= sample_in;
            if (sample_cnt_r != SAMPLE_LAST) sample_cnt_r <= sample_cnt_r + SCW'(1);
          end else begin
            err_underrun_r <= 1'b1;
          end
        end
        S_WAIT_ENC: begin
          if (enc_done) rd_cnt_r <= '0;
        end
        S_RD_WAIT: out_data_r <= meas_data;
        S_RD_OUT: begin
          if (out_ready && (rd_cnt_r != RD_LAST)) rd_cnt_r <= rd_cnt_r + AW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef CS_SEQ_TIMEOUT_EN
  localparam int WCW = $clog2(TIMEOUT) + 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  logic [WCW-1:0] wait_cnt_r;
  logic           err_timeout_r;

  assign timeout_hit_s = (wait_cnt_r == WAIT_LAST);

  // Watchdog: counts WAIT_ENC cycles; a same-cycle enc_done takes priority over expiry
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_r    <= '0;
      err_timeout_r <= 1'b0;
    end else if (state_r == S_WAIT_ENC) begin
      if (!enc_done && timeout_hit_s) err_timeout_r <= 1'b1;
      if (!enc_done && !timeout_hit_s) wait_cnt_r <= wait_cnt_r + WCW'(1);
    end else begin
      wait_cnt_r <= '0;
      if ((state_r == S_IDLE) && start) err_timeout_r <= 1'b0;
    end
  end

  assign err_timeout = err_timeout_r;
`else
  assign timeout_hit_s = 1'b0;
  assign err_timeout   = 1'b0;
`endif

  assign sample_ready = sample_ready_r;
  assign dp_reset     = dp_reset_r;
  assign th_enable    = th_enable_r;
  assign th_sig       = th_sig_r;
  assign meas_addr    = rd_cnt_r;
  assign out_data     = out_data_r;
  assign out_valid    = out_valid_r;
  assign out_last     = out_last_r;
  assign busy         = busy_r;
  assign err_underrun = err_underrun_r;

endmodule

// File: tb/tb_cs_frame_sequencer.sv
// Bench for cs_frame_sequencer: a table of frame scenarios scored against a transaction-level
// model (samples in order, measurements read out in address order), plus reset/timeout sequences.
`timescale 1ns/1ps
module tb_cs_frame_sequencer;
  localparam int N  = 2048;
  localparam int M  = 512;
  localparam int DW = 12;
  localparam int MW = 24;
  localparam int AW = $clog2(M);
`ifdef CS_SEQ_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 8192;
`endif

  logic clk = 1'b0;
  logic reset, start, sample_valid, sample_ready, dp_reset, th_enable, enc_done;
  logic out_valid, out_ready, out_last, busy, err_underrun, err_timeout;
  logic [DW-1:0] sample_in, th_sig;
  logic [AW-1:0] meas_addr;
  logic [MW-1:0] meas_data, out_data;
  logic [MW-1:0] mem [M];
  int checks = 0;
  int errors = 0;

  typedef struct {
    int underrun_at;
    int enc_delay;
    int ready_mode;
    bit rand_data;
    bit poke;
    bit exp_underrun;
  } vec_t;
  vec_t tbl [7];

  cs_frame_sequencer #(.N(N), .M(M), .DW(DW), .MW(MW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .sample_in(sample_in),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .dp_reset(dp_reset),
    .th_enable(th_enable), .th_sig(th_sig), .enc_done(enc_done), .meas_addr(meas_addr),
    .meas_data(meas_data), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .err_underrun(err_underrun), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // measurement bank: registered read, data one cycle after address
  always @(posedge clk) meas_data <= mem[meas_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int underrun_at, input int enc_delay, input int ready_mode,
                           input bit rand_data, input bit poke, input bit exp_underrun,
                           input int reset_at);
    logic [DW-1:0] smp [N];
    logic [MW-1:0] expv [M];
    logic [DW-1:0] last;
    logic [MW-1:0] prev_data;
    int acc, hs, steps;
    bit ok, prev_stall;
    for (int i = 0; i < M; i++) begin
      mem[i]  = rand_data ? MW'($urandom) : MW'(i * 3);
      expv[i] = mem[i];
    end
    for (int i = 0; i < N; i++) smp[i] = rand_data ? DW'($urandom) : DW'(i);

    start = 1'b1; sample_valid = 1'b1; sample_in = smp[0];
    step();
    start = 1'b0;
    chk("arm_rst_dp_reset", dp_reset, 1'b1);
    chk("arm_rst_th_enable", th_enable, 1'b0);
    chk("start_clears_errors", {err_underrun, err_timeout}, 2'b00);
    chk("arm_busy", busy, 1'b1);
    step();
    chk("arm_en_dp_reset", dp_reset, 1'b0);
    chk("arm_en_th_enable", th_enable, 1'b1);
    chk("arm_en_sample_ready", sample_ready, 1'b0);
    step();
    chk("stream_th_enable", th_enable, 1'b0);

    acc = 0; last = th_sig;
    while (acc < N) begin
      sample_valid = (acc != underrun_at);
      sample_in    = smp[acc];
      start        = poke && (acc % 97 == 5);
      enc_done     = poke && (acc % 13 == 0);
      chk("stream_ready", sample_ready, 1'b1);
      if (sample_ready !== 1'b1) break;
      step();
      if (!sample_valid) break;
      last = smp[acc];
      acc++;
      chk("th_sig", th_sig, last);
      if (th_sig !== last) break;
    end
    start = 1'b0; enc_done = 1'b0; sample_valid = 1'b0;

    if (acc == underrun_at) begin
      chk("underrun_flag", err_underrun, 1'b1);
      chk("underrun_dp_reset", dp_reset, 1'b1);
      chk("underrun_ready", sample_ready, 1'b0);
      chk("underrun_th_sig_hold", th_sig, last);
      step();
      chk("underrun_idle", busy, 1'b0);
      chk("underrun_dp_reset_once", dp_reset, 1'b0);
      ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
        step();
        if (out_valid || busy || !err_underrun) ok = 1'b0;
      end
      chk("underrun_sticky_no_output", ok, 1'b1);
      chk("err_underrun_expect", err_underrun, exp_underrun);
      return;
    end
    if (acc < N) return;

    chk("post_stream_ready", sample_ready, 1'b0);
    chk("wait_busy", busy, 1'b1);

`ifdef CS_SEQ_TIMEOUT_EN
    if (enc_delay < 0) begin
      ok = 1'b1;
      for (int i = 0; i < TO - 1; i++) begin
        step();
        if (err_timeout || !busy || dp_reset || out_valid) ok = 1'b0;
      end
      chk("timeout_wait", ok, 1'b1);
      step();
      chk("timeout_err", err_timeout, 1'b1);
      chk("timeout_dp_reset", dp_reset, 1'b1);
      chk("timeout_no_valid", out_valid, 1'b0);
      step();
      chk("timeout_idle", busy, 1'b0);
      chk("timeout_sticky", err_timeout, 1'b1);
      return;
    end
`endif

    ok = 1'b1;
    for (int i = 0; i < enc_delay; i++) begin
      step();
      if (out_valid || !busy || err_timeout) ok = 1'b0;
    end
    chk("wait_hold", ok, 1'b1);
    enc_done = 1'b1;
    step();
    enc_done = 1'b0;

    hs = 0; steps = 0; prev_stall = 1'b0; prev_data = '0;
    while (hs < M && steps < 10 * M) begin
      if (hs == reset_at) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_dp_reset", dp_reset, 1'b1);
        chk("rst_misc", {th_enable, sample_ready, err_underrun, err_timeout}, 4'b0000);
        chk("rst_th_sig", th_sig, '0);
        chk("rst_meas_addr", meas_addr, '0);
        step();
        chk("rst_release_dp_reset", dp_reset, 1'b0);
        chk("rst_release_idle", busy, 1'b0);
        out_ready = 1'b0;
        return;
      end
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (steps % 4 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        chk("out_data", out_data, expv[hs]);
        chk("out_last", out_last, (hs == M - 1));
        hs++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      step();
      steps++;
    end
    out_ready = 1'b0;
    chk("word_count", hs, M);
    if (ready_mode == 0) chk("throughput_cycles", steps, 3 * M);
    chk("done_idle", busy, 1'b0);
    chk("done_valid_low", out_valid, 1'b0);
    step(); step(); step();
    chk("no_queued_start", busy, 1'b0);
    chk("err_underrun_expect", err_underrun, exp_underrun);
    chk("err_timeout_clear", err_timeout, 1'b0);
  endtask

  initial begin
    tbl[0] = '{-1,     10, 0, 1'b0, 1'b0, 1'b0};  // nominal ramp, addr*3
    tbl[1] = '{-1,      5, 1, 1'b0, 1'b0, 1'b0};  // backpressure 1-of-4
    tbl[2] = '{100,     0, 0, 1'b0, 1'b0, 1'b1};  // underrun at sample 100
    tbl[3] = '{-1,     15, 2, 1'b1, 1'b1, 1'b0};  // recovery; start/enc_done noise in STREAM
    tbl[4] = '{0,       0, 0, 1'b0, 1'b0, 1'b1};  // underrun on first sample
    tbl[5] = '{N - 1,   0, 0, 1'b1, 1'b0, 1'b1};  // underrun on last sample
    tbl[6] = '{-1,      0, 2, 1'b1, 1'b0, 1'b0};
    tbl[6].enc_delay = $urandom_range(0, 12);

    reset = 1'b1; start = 1'b0; sample_valid = 1'b0; sample_in = '0;
    enc_done = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < M; i++) mem[i] = '0;
    step(); step();
    chk("reset_dp_reset", dp_reset, 1'b1);
    chk("reset_outputs", {sample_ready, th_enable, out_valid, out_last, busy, err_underrun, err_timeout}, 7'b0);
    chk("reset_data", {th_sig, out_data, meas_addr}, '0);
    reset = 1'b0;
    step();
    chk("idle_dp_reset", dp_reset, 1'b0);
    chk("idle_busy", busy, 1'b0);

    for (int i = 0; i < 7; i++)
      run_frame(tbl[i].underrun_at, tbl[i].enc_delay, tbl[i].ready_mode,
                tbl[i].rand_data, tbl[i].poke, tbl[i].exp_underrun, -1);

    // start noise during STREAM, then reset after 200 words
    run_frame(-1, 4, 0, 1'b1, 1'b1, 1'b0, 200);
    run_frame(-1, 10, 0, 1'b0, 1'b0, 1'b0, -1);

`ifdef CS_SEQ_TIMEOUT_EN
    run_frame(-1, -1, 0, 1'b0, 1'b0, 1'b0, -1);
    run_frame(-1, TO - 1, 0, 1'b1, 1'b0, 1'b0, -1);
`else
    run_frame(-1, 20000, 0, 1'b1, 1'b0, 1'b0, -1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cs_frame_sequencer.md
Name: cs_frame_sequencer

Overview:
Frame-level controller for the compressed-sensing ECG datapath (thresholding -> encoder). It arms the datapath, streams exactly N input samples into the thresholding stage, waits for the encoder to finish, then reads the M measurements out of the encoder accumulator bank onto a valid/ready output stream. It is the single owner of the datapath's reset and enable, and it re-arms for each frame.

Parameters:
N, 2048, samples per frame.
M, 512, measurements per frame.
DW, 12, sample width (signed).
MW, 24, measurement width (signed).
TIMEOUT, 8192, maximum cycles in WAIT_ENC before abort (used only with CS_SEQ_TIMEOUT_EN).

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous active-high reset
start  in  1  request one frame; sampled only in IDLE
sample_in  in  DW  ECG sample, signed
sample_valid  in  1  sample_in valid
sample_ready  out  1  sequencer accepts sample this cycle
dp_reset  out  1  synchronous reset to thresholding/encoder
th_enable  out  1  one-cycle start pulse to thresholding
th_sig  out  DW  registered sample to thresholding
enc_done  in  1  encoder finished frame (level or pulse)
meas_addr  out  log2(M)  measurement read address
meas_data  in  MW  measurement at meas_addr, valid 1 cycle after address
out_data  out  MW  measurement output
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts
out_last  out  1  marks measurement M-1
busy  out  1  high in any state except IDLE
err_underrun  out  1  sticky: sample_valid low during STREAM
err_timeout  out  1  sticky: WAIT_ENC timeout (0 if feature off)

Behaviour:
- Reset: state=IDLE; all outputs 0 except dp_reset=1 (datapath held in reset while sequencer resets); counters 0; sticky errors cleared. Reset mid-frame aborts immediately, no partial output.
- IDLE: dp_reset=0, sample_ready=0. start=1 -> ARM_RST. Errors stay sticky until reset or next start (start clears both).
- ARM_RST: dp_reset=1 for exactly 1 cycle -> ARM_EN.
- ARM_EN: th_enable=1 for exactly 1 cycle; sample_ready=0 -> STREAM.
- STREAM: sample_ready=1. Each cycle sample_valid=1: th_sig<=sample_in, sample_cnt++. Datapath cannot stall: sample_valid=0 in any STREAM cycle -> set err_underrun, go ABORT. After sample N-1 accepted -> WAIT_ENC (sample_ready=0 that same next cycle). th_sig holds last value outside STREAM.
- WAIT_ENC: enc_done=1 -> RD_ADDR with rd_cnt=0. enc_done high during STREAM is ignored.
- RD_ADDR: meas_addr=rd_cnt -> RD_WAIT. RD_WAIT: capture meas_data into out_data, out_valid=1, out_last=(rd_cnt==M-1) -> RD_OUT.
- RD_OUT: hold out_data/out_valid/out_last stable until out_ready=1. On handshake: out_valid=0 next cycle; if rd_cnt==M-1 -> IDLE, else rd_cnt++ -> RD_ADDR. Throughput: one word per 3 cycles with out_ready tied high. out_ready high before out_valid has no effect.
- ABORT: dp_reset=1 one cycle, out_valid=0 -> IDLE.
- Counters: sample_cnt width log2(N)+1, rd_cnt log2(M); no wrap beyond N-1 / M-1.
- start while busy: ignored, no queuing.

Optional Feature:
CS_SEQ_TIMEOUT_EN: defined -> cycle counter runs in WAIT_ENC; reaching TIMEOUT cycles without enc_done sets err_timeout and goes ABORT; enc_done on the same cycle as the TIMEOUT count wins (proceed to RD_ADDR). Undefined -> WAIT_ENC waits indefinitely, err_timeout tied 0, no counter logic.

Test Plan:
- Nominal frame: reset, start, 2048 consecutive samples 0..2047, enc_done 10 cycles later, memory model meas_data=addr*3, out_ready=1 -> dp_reset 1 cycle, th_enable 1 cycle, th_sig follows input 1 cycle late, 512 outputs 0,3,...,1533, out_last only on 1533, busy drops after last handshake.
- Backpressure: out_ready toggling 1-of-4 cycles -> out_data stable while out_valid and !out_ready, no drops or duplicates, 512 words in order.
- Underrun: sample_valid low at sample 100 -> err_underrun=1, one dp_reset pulse, IDLE, no out_valid; next start clears err_underrun and runs a full frame.
- Start while busy plus reset mid-readout: start pulses during STREAM ignored; reset at word 200 -> all outputs at reset values next cycle, dp_reset=1.
- Timeout (macro on, TIMEOUT=16): enc_done never asserted -> err_timeout after 16 WAIT_ENC cycles, ABORT, IDLE; enc_done on cycle 16 -> normal readout, err_timeout=0.
- Macro off: enc_done delayed 20000 cycles -> still waiting, then normal readout, err_timeout=0 throughout.
